skin_map_downsampler: RTL and testbench



---
 rtl/skin_map_downsampler.sv | 102 ++++++++++
 tb/tb_skin_map_downsampler.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/skin_map_downsampler.sv
// Reduces a 640x480 skin-detect pixel stream to one 16-bit cell word per 16x16 block,
// writing each cell to the skin-map RAM one clock after its block-final pixel.
module skin_map_downsampler #(
  parameter int H_CELLS = 40,
  parameter int V_CELLS = 30,
  parameter int THRESH  = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sof,
  input  logic        pix_valid,
  input  logic [9:0]  pix_x,
  input  logic [8:0]  pix_y,
  input  logic        pix_skin,
  output logic        ram_we,
  output logic [10:0] ram_addr,
  output logic [15:0] ram_data,
  output logic        frame_done
);

  localparam logic [8:0] THRESH_C = 9'(THRESH);
  localparam logic [5:0] LAST_CX  = 6'(H_CELLS - 1);
  localparam logic [4:0] LAST_CY  = 5'(V_CELLS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [8:0]  acc_q [H_CELLS];
  logic [8:0]  acc_d [H_CELLS];
  logic        ram_we_q, ram_we_d;
  logic [10:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_data_q, ram_data_d;
  logic        frame_done_q, frame_done_d;

  logic [5:0]  cx;
  logic [4:0]  cy;
  logic        in_range, accept, blk_final;
  logic [8:0]  base, cnt;

  function automatic logic [15:0] pack_cell(input logic [8:0] count);
    return {(count >= THRESH_C), 6'b0, count};
  endfunction

  always_comb begin
    cx        = pix_x[9:4];
    cy        = pix_y[8:4];
    in_range  = (cx < 6'(H_CELLS)) && (cy < 5'(V_CELLS));
    // sof opens the frame in the same cycle, so a coincident pixel is counted
    accept    = pix_valid && in_range && ((state_q == RUN) || sof);
    blk_final = (&pix_x[3:0]) && (&pix_y[3:0]);
    base      = sof ? 9'd0 : acc_q[cx];
    cnt       = base + {8'd0, pix_skin};

    for (int i = 0; i < H_CELLS; i++) begin
      acc_d[i] = sof ? 9'd0 : acc_q[i];
    end
    if (accept) begin
      acc_d[cx] = blk_final ? 9'd0 : cnt;
    end

    ram_we_d     = accept && blk_final;
    ram_addr_d   = ram_we_d ? {cx, cy} : ram_addr_q;
    ram_data_d   = ram_we_d ? pack_cell(cnt) : ram_data_q;
    frame_done_d = ram_we_d && (cx == LAST_CX) && (cy == LAST_CY);

    state_d = state_q;
    if (sof) begin
      state_d = RUN;
    end else if (frame_done_d) begin
      state_d = IDLE;
    end
  end

  // Register stage: one clock from block-final pixel to RAM write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < H_CELLS; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < H_CELLS; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_skin_map_downsampler.sv
// Directed bench for skin_map_downsampler: drives short pixel sequences and
// checks each cell write against hand-computed addresses and cell words.
module tb_skin_map_downsampler;

  logic        clk;
  logic        reset;
  logic        sof;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_skin;
  logic        ram_we;
  logic [10:0] ram_addr;
  logic [15:0] ram_data;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int w0;

  skin_map_downsampler #(.H_CELLS(40), .V_CELLS(30), .THRESH(128)) dut (
    .clk        (clk),
    .reset      (reset),
    .sof        (sof),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_skin   (pix_skin),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one input cycle, then sample just after the capturing edge.
  task automatic cyc(input int x, input int y, input logic s, input logic v, input logic sf);
    @(negedge clk);
    pix_x = 10'(x); pix_y = 9'(y); pix_skin = s; pix_valid = v; sof = sf;
    @(posedge clk);
    #1;
    if (ram_we === 1'b1) wr_cnt++;
  endtask

  task automatic check_write(input string tag, input int addr, input int data, input logic fd);
    chk({tag, "_we"},   32'(ram_we), 32'd1);
    chk({tag, "_addr"}, 32'(ram_addr), 32'(addr));
    chk({tag, "_data"}, 32'(ram_data), 32'(data));
    chk({tag, "_fd"},   32'(frame_done), 32'(fd));
  endtask

  // kind 0: first n pixels of the cell in raster order are skin; kind 1: left 8 columns skin
  task automatic send_cell(input int cx, input int cy, input int kind, input int n, input bit gap);
    logic s;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        s = (kind == 0) ? ((y * 16 + x) < n) : (x < 8);
        if (gap) cyc($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b0, 1'b0);
        cyc(cx * 16 + x, cy * 16 + y, s, 1'b1, 1'b0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; sof = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_skin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we",   32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_data", 32'(ram_data), 32'd0);
    chk("rst_fd",   32'(frame_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // IDLE ignores a block-final pixel
    cyc(15, 15, 1'b1, 1'b1, 1'b0);
    chk("idle_no_we", 32'(ram_we), 32'd0);

    cyc(0, 0, 1'b0, 1'b0, 1'b1);
    w0 = wr_cnt;
    send_cell(0, 0, 0, 256, 1'b0);
    check_write("full", 0, 16'h8100, 1'b0);
    chk("full_wrcnt", 32'(wr_cnt), 32'(w0 + 1));

    send_cell(1, 0, 1, 0, 1'b0);
    check_write("half", 32, 16'h8080, 1'b0);

    send_cell(2, 0, 0, 127, 1'b0);
    check_write("c127", 64, 16'h007F, 1'b0);

    cyc(15, 15, 1'b1, 1'b1, 1'b0);
    check_write("single", 0, 16'h0001, 1'b0);
    cyc(3, 3, 1'b1, 1'b0, 1'b0);
    chk("hold_we",   32'(ram_we), 32'd0);
    chk("hold_addr", 32'(ram_addr), 32'd0);
    chk("hold_data", 32'(ram_data), 32'h0001);
    cyc(15, 15, 1'b0, 1'b1, 1'b0);
    check_write("cleared", 0, 16'h0000, 1'b0);

    // Out-of-range pixels with block-final low bits must not write
    w0 = wr_cnt;
    cyc(655, 15, 1'b1, 1'b1, 1'b0);
    cyc(15, 495, 1'b1, 1'b1, 1'b0);
    chk("oor_wrcnt", 32'(wr_cnt), 32'(w0));

    w0 = wr_cnt;
    send_cell(3, 1, 0, 256, 1'b1);
    check_write("gapped", 97, 16'h8100, 1'b0);
    chk("gapped_wrcnt", 32'(wr_cnt), 32'(w0 + 1));

    for (int x = 80; x < 90; x++) cyc(x, 0, 1'b1, 1'b1, 1'b0);
    cyc(95, 15, 1'b1, 1'b1, 1'b1);
    check_write("sof_pix", 160, 16'h0001, 1'b0);

    // Partial data in cell (20,12), then mid-frame sof discards it
    for (int y = 192; y < 198; y++)
      for (int x = 320; x < 336; x++) cyc(x, y, 1'b1, 1'b1, 1'b0);
    cyc(0, 0, 1'b0, 1'b0, 1'b1);
    send_cell(20, 12, 0, 200, 1'b0);
    check_write("abort", 652, 16'h80C8, 1'b0);

    cyc(639, 479, 1'b1, 1'b1, 1'b0);
    check_write("last", 1277, 16'h0001, 1'b1);
    cyc(0, 0, 1'b0, 1'b0, 1'b0);
    chk("fd_pulse", 32'(frame_done), 32'd0);
    cyc(15, 15, 1'b1, 1'b1, 1'b0);
    chk("done_idle", 32'(ram_we), 32'd0);

    // sof coincident with the frame-final write keeps the block running
    cyc(0, 0, 1'b0, 1'b0, 1'b1);
    cyc(639, 479, 1'b1, 1'b1, 1'b1);
    check_write("sof_fd", 1277, 16'h0001, 1'b1);
    cyc(15, 15, 1'b1, 1'b1, 1'b0);
    check_write("sof_fd_run", 0, 16'h0001, 1'b0);

    // Asynchronous reset in the middle of a write cycle
    cyc(31, 15, 1'b1, 1'b1, 1'b0);
    check_write("pre_rst", 32, 16'h0001, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_we",   32'(ram_we), 32'd0);
    chk("arst_addr", 32'(ram_addr), 32'd0);
    chk("arst_data", 32'(ram_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    w0 = wr_cnt;
    cyc(47, 15, 1'b1, 1'b1, 1'b0);
    cyc(639, 479, 1'b1, 1'b1, 1'b0);
    chk("arst_idle_wrcnt", 32'(wr_cnt), 32'(w0));
    chk("arst_idle_fd", 32'(frame_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
